// File: rtl/ysyx_24100006_wbu_if.sv
// Handshake bundle between the memory-access stage and write-back.
// The mem stage is the master; the write-back unit is the slave.
interface ysyx_24100006_wbu_if;
    logic        wb_in_valid;
    logic        wb_in_ready;
    logic        is_break_i;
    logic        irq_i;
    logic        gpr_we_i;
    logic [3:0]  gpr_waddr_i;
    logic [31:0] gpr_wdata_i;
    logic        csr_we_i;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;

    modport master (
        output wb_in_valid, is_break_i, irq_i,
        output gpr_we_i, gpr_waddr_i, gpr_wdata_i,
        output csr_we_i, csr_waddr_i, csr_wdata_i,
        input  wb_in_ready
    );

    modport slave (
        input  wb_in_valid, is_break_i, irq_i,
        input  gpr_we_i, gpr_waddr_i, gpr_wdata_i,
        input  csr_we_i, csr_waddr_i, csr_wdata_i,
        output wb_in_ready
    );
endinterface

// File: rtl/ysyx_24100006_wbu.sv
// Write-back/commit stage: 1-entry holding register, RV32E GPR file,
// machine CSRs, retire/cycle counters and ebreak halt.
module ysyx_24100006_wbu #(
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
    parameter logic [31:0] TRAP_CAUSE  = 32'd11
) (
    input  logic                      clk,
    input  logic                      reset,
    ysyx_24100006_wbu_if.slave        up,
    input  logic                      wb_hold,
    input  logic [3:0]                rs1_addr,
    input  logic [3:0]                rs2_addr,
    output logic [31:0]               rs1_data,
    output logic [31:0]               rs2_data,
    input  logic [11:0]               csr_raddr,
    output logic [31:0]               csr_rdata,
    output logic [31:0]               mtvec_o,
    output logic                      fw_valid,
    output logic [3:0]                fw_addr,
    output logic [31:0]               fw_data,
    output logic                      commit_o,
    output logic                      halt_o
);
    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        halted;

    logic        valid_r;
    logic        brk_r;
    logic        irq_r;
    logic        gpr_we_r;
    logic [3:0]  gpr_waddr_r;
    logic [31:0] gpr_wdata_r;
    logic        csr_we_r;
    logic [11:0] csr_waddr_r;
    logic [31:0] csr_wdata_r;

    logic [31:0] regs [16];
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        commit;
    logic        accept;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:  if (commit && brk_r) state_nxt = HALT;
            HALT: state_nxt = HALT;
        endcase
    end

    always_comb begin
        halted = (state == HALT);
        halt_o = halted;
    end

    assign commit         = valid_r & ~wb_hold & ~halted;
    assign up.wb_in_ready = ~halted & (~valid_r | commit);
    assign accept         = up.wb_in_valid & up.wb_in_ready;
    assign commit_o       = commit;

    assign fw_valid = valid_r & gpr_we_r & (gpr_waddr_r != 4'd0);
    assign fw_addr  = gpr_waddr_r;
    assign fw_data  = gpr_wdata_r;
    assign mtvec_o  = mtvec;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r     <= 1'b0;
            brk_r       <= 1'b0;
            irq_r       <= 1'b0;
            gpr_we_r    <= 1'b0;
            gpr_waddr_r <= '0;
            gpr_wdata_r <= '0;
            csr_we_r    <= 1'b0;
            csr_waddr_r <= '0;
            csr_wdata_r <= '0;
        end else if (accept) begin
            valid_r     <= 1'b1;
            brk_r       <= up.is_break_i;
            irq_r       <= up.irq_i;
            gpr_we_r    <= up.gpr_we_i;
            gpr_waddr_r <= up.gpr_waddr_i;
            gpr_wdata_r <= up.gpr_wdata_i;
            csr_we_r    <= up.csr_we_i;
            csr_waddr_r <= up.csr_waddr_i;
            csr_wdata_r <= up.csr_wdata_i;
        end else if (commit) begin
            valid_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (commit && fw_valid) begin
            regs[gpr_waddr_r] <= gpr_wdata_r;
        end
    end

    // Trap entry takes precedence over any explicit CSR write it carries.
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus  <= MSTATUS_RST;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= mcycle + 64'd1;
            minstret <= minstret + 64'(commit);
            if (commit && irq_r) begin
                mepc       <= csr_wdata_r;
                mcause     <= TRAP_CAUSE;
                mstatus[7] <= mstatus[3];
                mstatus[3] <= 1'b0;
            end else if (commit && csr_we_r) begin
                case (csr_waddr_r)
                    12'h300: mstatus <= csr_wdata_r;
                    12'h305: mtvec   <= csr_wdata_r;
                    12'h341: mepc    <= csr_wdata_r;
                    12'h342: mcause  <= csr_wdata_r;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == 4'd0) ? 32'd0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 4'd0) ? 32'd0 : regs[rs2_addr];
        if (commit && fw_valid && fw_addr == rs1_addr) rs1_data = fw_data;
        if (commit && fw_valid && fw_addr == rs2_addr) rs2_data = fw_data;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            12'h300: csr_rdata = mstatus;
            12'h305: csr_rdata = mtvec;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'hB00: csr_rdata = mcycle[31:0];
            12'hB80: csr_rdata = mcycle[63:32];
            12'hB02: csr_rdata = minstret[31:0];
            12'hB82: csr_rdata = minstret[63:32];
            12'hF11: csr_rdata = 32'h7973_7978;
            12'hF12: csr_rdata = 32'd24100006;
            default: csr_rdata = '0;
        endcase
    end
endmodule
